// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: state encoding and default blink timing shared by every indicator instance
package pulse_stretch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;
    localparam int DEF_ON_TICKS  = 4;
    localparam int DEF_GAP_TICKS = 2;
endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: event input, time-base strobe and stretched indicator outputs
interface pulse_stretch_if #(
    parameter int PEND_W = 3
);
    logic              i_tick_en;
    logic              i_in_pulse;
    logic              o_out_level;
    logic              o_busy;
    logic [PEND_W-1:0] o_pending;
    logic              o_overflow;
    modport master (
        output i_tick_en, i_in_pulse,
        input  o_out_level, o_busy, o_pending, o_overflow
    );
    modport slave (
        input  i_tick_en, i_in_pulse,
        output o_out_level, o_busy, o_pending, o_overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle events into ON/GAP blinks, queueing events that arrive while busy
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int CNT_W     = 8,
    parameter int PEND_W    = 3
) (
    input logic            clk,
    input logic            rst,
    pulse_stretch_if.slave bus
);
    localparam logic [CNT_W-1:0]  ON_CNT   = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0]  GAP_CNT  = CNT_W'(GAP_TICKS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt, w_cnt_inc;
    logic [PEND_W-1:0] r_pend, w_pend;
    logic              r_out, r_busy, r_ovf, w_ovf;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_pend = r_pend;
        w_ovf  = 1'b0;
        case (r_state)
            IDLE: if (bus.i_in_pulse || r_pend != '0) begin
                w_next = ON;
                w_cnt  = '0;
                if (!bus.i_in_pulse) w_pend = r_pend - PEND_W'(1);
            end
            ON: if (bus.i_tick_en) begin
                w_cnt = w_cnt_inc;
                if (w_cnt_inc == ON_CNT) begin
                    w_next = (GAP_TICKS == 0) ? IDLE : GAP;
                    w_cnt  = '0;
                end
            end
            GAP: if (bus.i_tick_en) begin
                w_cnt = w_cnt_inc;
                if (w_cnt_inc == GAP_CNT) begin
                    w_next = IDLE;
                    w_cnt  = '0;
                end
            end
            default: begin
                w_next = IDLE;
                w_cnt  = '0;
            end
        endcase
        // while blinking, a new event is queued; a full queue drops it and flags overflow
        if ((r_state == ON || r_state == GAP) && bus.i_in_pulse) begin
            if (r_pend == PEND_MAX) w_ovf = 1'b1;
            else w_pend = r_pend + PEND_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_pend  <= w_pend;
            r_out   <= (w_next == ON);
            r_busy  <= (w_next != IDLE);
            r_ovf   <= w_ovf;
        end
    end
    assign bus.o_out_level = r_out;
    assign bus.o_busy      = r_busy;
    assign bus.o_pending   = r_pend;
    assign bus.o_overflow  = r_ovf;
endmodule
